bit_feed_ctrl: RTL and testbench

BIT_FEED_CTRL -- requirements
Module: bit_feed_ctrl

---
 rtl/bit_feed_ctrl_pkg.sv | 6 +
 rtl/bit_feed_ctrl_trig_timer.sv | 19 +
 rtl/bit_feed_ctrl.sv | 96 +++++++++
 tb/tb_bit_feed_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_feed_ctrl_pkg.sv
// bit_feed_ctrl_pkg: controller state encoding and the LED constant shared with the 11010 detector.
package bit_feed_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, WAIT, SHIFT, CHECK, DONE} state_t;
   localparam int LED_W_DEF = 5;
   localparam logic [LED_W_DEF-1:0] LED_MATCH = '1;
endpackage

// File: rtl/bit_feed_ctrl_trig_timer.sv
// trig_timer: loadable down-counter that times the idle gap before each serialized bit.
module trig_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   end
   assign zero = cnt == '0;
endmodule

// File: rtl/bit_feed_ctrl.sv
// bit_feed_ctrl: serializes words MSB first into an external 11010 detector and counts its completed matches.
module bit_feed_ctrl
   import bit_feed_ctrl_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int DIV_W  = 8,
   parameter int CNT_W  = 8,
   parameter int LED_W  = LED_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   input  logic [DIV_W-1:0]  div,
   output logic              word_ready,
   input  logic              clr_cnt,
   input  logic [LED_W-1:0]  det_led,
   output logic              det_data,
   output logic              det_trig,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              busy,
   output logic              done
);
   localparam int BIT_W = $clog2(WORD_W + 1);
   localparam logic [LED_W-1:0] MATCH = (LED_W == LED_W_DEF) ? LED_W'(LED_MATCH) : '1;
   state_t state, state_nx;
   logic [WORD_W-1:0] shift_r;
   logic [DIV_W-1:0]  div_r;
   logic [DIV_W-1:0]  tmr_val;
   logic [BIT_W-1:0]  bit_cnt;
   logic              accept;
   logic              tmr_zero;
   assign accept  = word_ready & word_valid;
   // The accepting cycle loads the live div; later bits reuse the captured copy.
   assign tmr_val = (state == IDLE) ? div : div_r;
   trig_timer #(.W(DIV_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept | (state == CHECK)),
      .load_val (tmr_val),
      .en       (state == WAIT),
      .zero     (tmr_zero)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx   = state;
      word_ready = 1'b0;
      busy       = 1'b1;
      det_trig   = 1'b0;
      det_data   = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            word_ready = 1'b1;
            busy       = 1'b0;
            if (word_valid) state_nx = WAIT;
         end
         WAIT:  if (tmr_zero) state_nx = SHIFT;
         SHIFT: begin
            det_trig = 1'b1;
            det_data = shift_r[WORD_W-1];
            state_nx = CHECK;
         end
         CHECK: state_nx = (bit_cnt == '0) ? DONE : WAIT;
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_r   <= '0;
         div_r     <= '0;
         bit_cnt   <= '0;
         match_cnt <= '0;
      end else begin
         if (accept) begin
            shift_r <= word_data;
            div_r   <= div;
            bit_cnt <= BIT_W'(WORD_W);
         end
         if (state == SHIFT) begin
            shift_r <= shift_r << 1;
            bit_cnt <= bit_cnt - 1'b1;
         end
         // Clear has priority over a coincident detection.
         if (clr_cnt) match_cnt <= '0;
         else if (state == CHECK && det_led == MATCH && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_bit_feed_ctrl.sv
// tb_bit_feed_ctrl: drives words through bit_feed_ctrl with a behavioural 11010 detector and scoreboards the results.
module tb_bit_feed_ctrl;
   localparam int WORD_W = 8;
   localparam int DIV_W  = 8;
   localparam int CNT_W  = 2;
   localparam int LED_W  = 5;
   typedef struct {
      logic [7:0] bits;
      int         per;
      int         lat;
      logic [1:0] mc;
   } exp_t;
   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              word_valid = 1'b0;
   logic [WORD_W-1:0] word_data = '0;
   logic [DIV_W-1:0]  div = '0;
   logic              clr_cnt = 1'b0;
   logic [LED_W-1:0]  det_led;
   logic              word_ready, det_data, det_trig, busy, done;
   logic [CNT_W-1:0]  match_cnt;
   exp_t              sb[$];
   int                n_cmp = 0;
   int                n_err = 0;
   int                prog;
   always #5 clk = ~clk;
   bit_feed_ctrl #(.WORD_W(WORD_W), .DIV_W(DIV_W), .CNT_W(CNT_W), .LED_W(LED_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .word_valid (word_valid),
      .word_data  (word_data),
      .div        (div),
      .word_ready (word_ready),
      .clr_cnt    (clr_cnt),
      .det_led    (det_led),
      .det_data   (det_data),
      .det_trig   (det_trig),
      .match_cnt  (match_cnt),
      .busy       (busy),
      .done       (done)
   );
   function automatic int det_next(input int p, input logic b);
      case (p)
         0: return b ? 1 : 0;
         1: return b ? 2 : 0;
         2: return b ? 2 : 3;
         3: return b ? 4 : 0;
         4: return b ? 2 : 5;
         default: return b ? 1 : 0;
      endcase
   endfunction
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) prog <= 0;
      else if (det_trig) prog <= det_next(prog, det_data);
   end
   assign det_led = LED_W'((32'd1 << prog) - 32'd1);
   task automatic drive_word(input logic [7:0] d, input logic [7:0] dv, input int clr_bit,
                             output int lat, output logic [7:0] bits, output int nb,
                             output int per, output logic [15:0] mc_all);
      int last, step;
      lat = -1; bits = '0; nb = 0; per = 0; mc_all = '0; last = 0; step = 0;
      @(negedge clk);
      word_valid = 1'b1; word_data = d; div = dv;
      for (int i = 0; i < 50 && !word_ready; i++) @(negedge clk);
      if (!word_ready) begin
         word_valid = 1'b0;
         return;
      end
      @(negedge clk);
      word_valid = 1'b0; word_data = ~d; div = ~dv;
      for (int c = 1; c <= 400; c++) begin
         if (step == 2) begin clr_cnt = 1'b0; step = 0; end
         if (step == 1) begin clr_cnt = 1'b1; step = 2; end
         if (det_trig) begin
            bits = {bits[6:0], det_data};
            if (nb < 8) mc_all[2*nb +: 2] = match_cnt;
            if (nb == 1) per = c - last;
            else if (nb > 1 && c - last != per) per = -1;
            last = c;
            nb++;
            if (nb == clr_bit) step = 1;
         end
         if (done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      clr_cnt = 1'b0;
   endtask
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (word_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", word_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
      n_cmp++; if (det_trig !== 1'b0) begin n_err++; $display("FAIL rst_trig got %b want 0", det_trig); end
      n_cmp++; if (det_data !== 1'b0) begin n_err++; $display("FAIL rst_data got %b want 0", det_data); end
      n_cmp++; if (match_cnt !== 2'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", match_cnt); end
      reset_n = 1'b1;
   endtask
   task automatic run_and_check(input string nm, input logic [7:0] d, input logic [7:0] dv, input int clr_bit, output logic [15:0] mc_all);
      int lat, nb, per;
      logic [7:0] bits;
      exp_t e;
      drive_word(d, dv, clr_bit, lat, bits, nb, per, mc_all);
      e = sb.pop_front();
      n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL %s_latency got %0d want %0d", nm, lat, e.lat); end
      n_cmp++; if (nb !== 8 || bits !== e.bits) begin n_err++; $display("FAIL %s_bits got %h/%0d want %h/8", nm, bits, nb, e.bits); end
      n_cmp++; if (per !== e.per) begin n_err++; $display("FAIL %s_period got %0d want %0d", nm, per, e.per); end
      n_cmp++; if (match_cnt !== e.mc) begin n_err++; $display("FAIL %s_match got %0d want %0d", nm, match_cnt, e.mc); end
   endtask
   task automatic test_div0();
      logic [15:0] mc;
      sb.push_back('{8'hDA, 3, 25, 2'd1});
      run_and_check("div0", 8'hDA, 8'd0, 0, mc);
   endtask
   task automatic test_div3();
      logic [15:0] mc;
      sb.push_back('{8'hD6, 6, 49, 2'd2});
      run_and_check("div3", 8'hD6, 8'd3, 0, mc);
      n_cmp++; if (mc[9:8] !== 2'd1) begin n_err++; $display("FAIL div3_cnt_bit5 got %0d want 1", mc[9:8]); end
      n_cmp++; if (mc[11:10] !== 2'd2) begin n_err++; $display("FAIL div3_cnt_bit6 got %0d want 2", mc[11:10]); end
   endtask
   task automatic test_zero();
      logic [15:0] mc;
      sb.push_back('{8'h00, 4, 33, 2'd2});
      run_and_check("zero", 8'h00, 8'd1, 0, mc);
      n_cmp++; if (det_led !== 5'b00000) begin n_err++; $display("FAIL zero_led got %b want 00000", det_led); end
   endtask
   task automatic test_saturate();
      logic [15:0] mc;
      logic [1:0]  want [4];
      want = '{2'd1, 2'd2, 2'd3, 2'd3};
      @(negedge clk); clr_cnt = 1'b1;
      @(negedge clk); clr_cnt = 1'b0;
      n_cmp++; if (match_cnt !== 2'd0) begin n_err++; $display("FAIL clr_idle got %0d want 0", match_cnt); end
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{8'hDA, 3, 25, want[i]});
         run_and_check("sat", 8'hDA, 8'd0, 0, mc);
      end
   endtask
   task automatic test_reset_mid();
      int nt = 0;
      int saw_done = 0;
      logic [15:0] mc;
      @(negedge clk);
      word_valid = 1'b1; word_data = 8'hDA; div = 8'd0;
      @(negedge clk);
      word_valid = 1'b0;
      for (int c = 0; c < 100 && nt < 4; c++) begin
         if (det_trig) nt++;
         if (nt < 4) @(negedge clk);
      end
      n_cmp++; if (nt !== 4) begin n_err++; $display("FAIL mid_reach_bit4 got %0d want 4", nt); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (word_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b want 1", word_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
      n_cmp++; if (det_trig !== 1'b0 || det_data !== 1'b0) begin n_err++; $display("FAIL mid_det got %b%b want 00", det_trig, det_data); end
      n_cmp++; if (match_cnt !== 2'd0) begin n_err++; $display("FAIL mid_cnt got %0d want 0", match_cnt); end
      repeat (4) begin
         @(negedge clk);
         if (done) saw_done++;
      end
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done++;
      end
      n_cmp++; if (saw_done !== 0) begin n_err++; $display("FAIL mid_no_done got %0d want 0", saw_done); end
      sb.push_back('{8'hDA, 3, 25, 2'd1});
      run_and_check("after_rst", 8'hDA, 8'd0, 0, mc);
   endtask
   task automatic test_clr_coincident();
      logic [15:0] mc;
      sb.push_back('{8'hDA, 3, 25, 2'd0});
      run_and_check("clr_win", 8'hDA, 8'd0, 8, mc);
      n_cmp++; if (mc[15:14] !== 2'd1) begin n_err++; $display("FAIL clr_win_pre got %0d want 1", mc[15:14]); end
   endtask
   task automatic test_back_to_back();
      logic [7:0] w [3];
      logic       bq[$];
      logic       b;
      int         acc = 0;
      int         dn = 0;
      int         viol = 0;
      bit         pend = 1'b0;
      w = '{8'hDA, 8'hD6, 8'h3C};
      for (int i = 0; i < 3; i++)
         for (int j = 7; j >= 0; j--) bq.push_back(w[i][j]);
      @(negedge clk);
      word_valid = 1'b1; div = 8'd0; word_data = w[0];
      for (int c = 0; c < 300 && dn < 3; c++) begin
         if (pend) begin word_data = w[acc < 3 ? acc : 2]; pend = 1'b0; end
         if (word_ready && busy) viol++;
         if (word_ready) begin acc++; pend = 1'b1; end
         if (det_trig) begin
            n_cmp++;
            if (bq.size() == 0) begin n_err++; $display("FAIL b2b_extra_bit got %b want none", det_data); end
            else begin
               b = bq.pop_front();
               if (det_data !== b) begin n_err++; $display("FAIL b2b_bit got %b want %b", det_data, b); end
            end
         end
         if (done) begin
            dn++;
            if (dn == 3) word_valid = 1'b0;
         end
         if (dn < 3) @(negedge clk);
      end
      word_valid = 1'b0;
      n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL b2b_accepts got %0d want 3", acc); end
      n_cmp++; if (dn !== 3) begin n_err++; $display("FAIL b2b_dones got %0d want 3", dn); end
      n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL b2b_ready_busy got %0d want 0", viol); end
      n_cmp++; if (bq.size() !== 0) begin n_err++; $display("FAIL b2b_left_bits got %0d want 0", bq.size()); end
   endtask
   initial begin
      test_reset();
      test_div0();
      test_div3();
      test_zero();
      test_saturate();
      test_reset_mid();
      test_clr_coincident();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
